// File: rtl/add_sub_pipe.sv
// Purpose : pipelined WIDTH-bit adder/subtractor; the carry chain is cut into STAGES chunks, one per register stage.
// Latency : STAGES clock edges from the accepting edge to valid_out, counting the accepting edge; one op per cycle.
// Backpr. : global enable en = !valid_out || out_ready freezes every stage; in_ready = en, bubbles are not collapsed.
//
// Ports:
//   clk, rst (async, active-low)
//   a, b, sub, start, tag_in   -> op input; accepted when start && in_ready at a clk edge
//   in_ready                   <- pipeline can accept this cycle
//   sum, carry, ovf, tag_out   <- result of the op at the output, qualified by valid_out
//   valid_out / out_ready      -> output handshake
module add_sub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAGW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             start,
  input  logic [TAGW-1:0]  tag_in,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic             valid_out,
  input  logic             out_ready,
  output logic [TAGW-1:0]  tag_out
);

  localparam int CW = WIDTH / STAGES;

  logic w_en;

  // One enable for the whole pipe: a stalled output freezes every stage,
  // even stages that currently hold bubbles.
  assign w_en     = !valid_out || out_ready;
  assign in_ready = w_en;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_st
      localparam int LO = k * CW;
      localparam int HI = LO + CW;

      // w_x carries finished sum bits below LO and still-unconsumed A bits from LO up.
      logic [WIDTH-1:0] w_x;
      logic [WIDTH-1:LO] w_b;
      logic             w_ci;
      logic             w_vi;
      logic [TAGW-1:0]  w_ti;
      logic [CW:0]      w_add;
      logic [WIDTH-1:0] w_nx;

      logic [WIDTH-1:0] r_x;
      logic             r_c;
      logic             r_v;
      logic [TAGW-1:0]  r_tag;

      if (k == 0) begin : g_src
        // Subtract is a + ~b + 1: invert B here and inject the +1 as chunk-0 carry-in.
        assign w_x  = a;
        assign w_b  = b ^ {WIDTH{sub}};
        assign w_ci = sub;
        assign w_vi = start;
        assign w_ti = tag_in;
      end else begin : g_src
        assign w_x  = g_st[k-1].r_x;
        assign w_b  = g_st[k-1].g_fwd.r_b;
        assign w_ci = g_st[k-1].r_c;
        assign w_vi = g_st[k-1].r_v;
        assign w_ti = g_st[k-1].r_tag;
      end

      assign w_add = {1'b0, w_x[HI-1:LO]} + {1'b0, w_b[HI-1:LO]} + (CW+1)'(w_ci);

      // The A chunk just consumed is overwritten in place by its sum chunk.
      always_comb begin
        w_nx        = w_x;
        w_nx[HI-1:LO] = w_add[CW-1:0];
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_x   <= '0;
          r_c   <= 1'b0;
          r_v   <= 1'b0;
          r_tag <= '0;
        end else if (w_en) begin
          r_x   <= w_nx;
          r_c   <= w_add[CW];
          r_v   <= w_vi;
          r_tag <= w_ti;
        end
      end

      if (k < STAGES-1) begin : g_fwd
        // Only the effective-B chunks later stages still need travel on.
        logic [WIDTH-1:HI] r_b;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            r_b <= '0;
          end else if (w_en) begin
            r_b <= w_b[WIDTH-1:HI];
          end
        end
      end else begin : g_ovf
        // Last stage still sees A[MSB] and effB[MSB] and produces sum[MSB].
        logic r_ovf;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            r_ovf <= 1'b0;
          end else if (w_en) begin
            r_ovf <= (w_x[WIDTH-1] == w_b[WIDTH-1]) && (w_add[CW-1] != w_x[WIDTH-1]);
          end
        end
      end
    end
  endgenerate

  assign sum       = g_st[STAGES-1].r_x;
  assign carry     = g_st[STAGES-1].r_c;
  assign valid_out = g_st[STAGES-1].r_v;
  assign tag_out   = g_st[STAGES-1].r_tag;
  assign ovf       = g_st[STAGES-1].g_ovf.r_ovf;

endmodule

// File: tb/tb_add_sub_pipe.sv
`timescale 1ns/1ps
module tb_add_sub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        sub, start, start_1, start_32, out_ready;
  logic [4:0]  tag_in;

  logic        in_ready, carry, ovf, valid_out;
  logic [31:0] sum;
  logic [4:0]  tag_out;

  logic        in_ready_1, carry_1, ovf_1, valid_1;
  logic [31:0] sum_1;
  logic [4:0]  tag_1;

  logic        in_ready_32, carry_32, ovf_32, valid_32;
  logic [31:0] sum_32;
  logic [4:0]  tag_32;

  always #5 clk = ~clk;

  add_sub_pipe #(.WIDTH(32), .STAGES(4), .TAGW(5)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sub(sub), .start(start), .tag_in(tag_in),
    .in_ready(in_ready), .sum(sum), .carry(carry), .ovf(ovf), .valid_out(valid_out),
    .out_ready(out_ready), .tag_out(tag_out));

  add_sub_pipe #(.WIDTH(32), .STAGES(1), .TAGW(5)) dut_1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .sub(sub), .start(start_1), .tag_in(tag_in),
    .in_ready(in_ready_1), .sum(sum_1), .carry(carry_1), .ovf(ovf_1), .valid_out(valid_1),
    .out_ready(1'b1), .tag_out(tag_1));

  add_sub_pipe #(.WIDTH(32), .STAGES(32), .TAGW(5)) dut_32 (
    .clk(clk), .rst(rst), .a(a), .b(b), .sub(sub), .start(start_32), .tag_in(tag_in),
    .in_ready(in_ready_32), .sum(sum_32), .carry(carry_32), .ovf(ovf_32), .valid_out(valid_32),
    .out_ready(1'b1), .tag_out(tag_32));

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic [4:0]  t;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;
  int   run   = 0;
  int   max_run = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range check for overflow.
  function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib,
                                 input logic is, input logic [4:0] it);
    exp_t        e;
    longint      sa, sbv, r;
    logic [32:0] u;
    sa  = longint'($signed(ia));
    sbv = longint'($signed(ib));
    if (!is) begin
      u   = {1'b0, ia} + {1'b0, ib};
      e.c = u[32];
      r   = sa + sbv;
    end else begin
      u   = {1'b0, ia} - {1'b0, ib};
      e.c = (ia >= ib);
      r   = sa - sbv;
    end
    e.s = u[31:0];
    e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.t = it;
    return e;
  endfunction

  // Output monitor for the STAGES=4 instance.
  always @(negedge clk) begin
    if (rst && valid_out) begin
      exp_t e;
      n_out++;
      run++;
      if (run > max_run) max_run = run;
      if (out_ready) begin
        if (sb.size() == 0) begin
          chk("stray_output", {63'd0, valid_out}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("sum",     {32'd0, sum},     {32'd0, e.s});
          chk("carry",   {63'd0, carry},   {63'd0, e.c});
          chk("ovf",     {63'd0, ovf},     {63'd0, e.o});
          chk("tag_out", {59'd0, tag_out}, {59'd0, e.t});
        end
      end
    end else begin
      run = 0;
    end
  end

  // Present an op and hold it until accepted; the scoreboard entry is pushed at acceptance.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic is, input logic [4:0] it);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    a = ia; b = ib; sub = is; tag_in = it; start = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (acc) sb.push_back(model(ia, ib, is, it));
    else     chk("accept_timeout", {63'd0, acc}, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t held;
    int   n0;
    rst = 1'b0; start = 1'b0; start_1 = 1'b0; start_32 = 1'b0;
    a = '0; b = '0; sub = 1'b0; tag_in = '0; out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_valid_out", {63'd0, valid_out}, 64'd0);
    chk("rst_sum",       {32'd0, sum},       64'd0);
    chk("rst_tag_out",   {59'd0, tag_out},   64'd0);
    chk("rst_flags",     {62'd0, carry, ovf}, 64'd0);
    chk("rst_valid_32",  {63'd0, valid_32},  64'd0);
    #1 rst = 1'b1;
    #1;
    chk("in_ready_after_rst", {61'd0, in_ready, in_ready_1, in_ready_32}, 64'd7);
    @(posedge clk); #1;

    // 1: carry ripples through every chunk boundary; latency 4 edges
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5'd5);
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("latency_early", {63'd0, valid_out}, 64'd0);
    @(posedge clk); #1;
    chk("latency_valid", {63'd0, valid_out}, 64'd1);
    chk("latency_sum",   {32'd0, sum},       64'd0);
    drain();

    // 2: signed overflow, add and subtract
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 5'd1);
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 5'd2);
    start = 1'b0;
    drain();

    // 3: 40 back-to-back random ops at full rate
    @(posedge clk); #1;
    max_run = 0;
    for (int i = 0; i < 40; i++) begin
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), 5'(i));
    end
    start = 1'b0;
    drain();
    repeat (2) begin @(posedge clk); #1; end
    chk("full_rate_run", 64'(max_run), 64'd40);

    // 4: fill the pipe with the output stalled, then release
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(32'h1000_0000 * (i + 1), 32'h0000_0123 + i, 1'b0, 5'(10 + i));
    end
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; sub = 1'b1; tag_in = 5'd14; start = 1'b1;
    held = sb[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {63'd0, in_ready},  64'd0);
      chk("stall_valid",    {63'd0, valid_out}, 64'd1);
      chk("stall_sum",      {32'd0, sum},       {32'd0, held.s});
      chk("stall_tag",      {59'd0, tag_out},   {59'd0, held.t});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 5'd14);
    issue(32'h0000_0010, 32'h0000_0020, 1'b1, 5'd15);
    start = 1'b0;
    drain();

    // 5: asynchronous reset with results parked at the output
    out_ready = 1'b0;
    issue(32'h0000_1111, 32'h0000_2222, 1'b0, 5'd20);
    issue(32'h0000_3333, 32'h0000_4444, 1'b0, 5'd21);
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_rst_valid", {63'd0, valid_out}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", {63'd0, valid_out}, 64'd0);
    chk("async_sum",   {32'd0, sum},       64'd0);
    chk("async_tag",   {59'd0, tag_out},   64'd0);
    chk("async_flags", {62'd0, carry, ovf}, 64'd0);
    rst = 1'b1;
    sb.delete();
    n0 = n_out;
    out_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("no_stale", 64'(n_out - n0), 64'd0);

    // 6: degenerate and fully split builds
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; sub = 1'b0; tag_in = 5'd7;
    start_1 = 1'b1; start_32 = 1'b1;
    @(posedge clk); #1;
    start_1 = 1'b0; start_32 = 1'b0;
    chk("s1_valid", {63'd0, valid_1}, 64'd1);
    chk("s1_sum",   {32'd0, sum_1},   64'hFFFF_FFFF);
    chk("s1_flags", {62'd0, carry_1, ovf_1}, 64'd0);
    chk("s1_tag",   {59'd0, tag_1},   64'd7);
    @(posedge clk); #1;
    chk("s1_single", {63'd0, valid_1}, 64'd0);
    repeat (29) begin @(posedge clk); #1; end
    chk("s32_early", {63'd0, valid_32}, 64'd0);
    @(posedge clk); #1;
    chk("s32_valid", {63'd0, valid_32}, 64'd1);
    chk("s32_sum",   {32'd0, sum_32},   64'hFFFF_FFFF);
    chk("s32_flags", {62'd0, carry_32, ovf_32}, 64'd0);
    chk("s32_tag",   {59'd0, tag_32},   64'd7);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
